// File: rtl/cdb_pkg.sv
// Shared constants for the CDB writeback stage:
// source ids, source count and the {tag, data} entry width helper.
package cdb_pkg;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_LSU = 2'd1;
  localparam logic [1:0] SRC_MUL = 2'd2;
  localparam int NUM_SRC = 3;

  function automatic int entry_w(int tag_w, int data_w);
    return tag_w + data_w;
  endfunction

endpackage

// File: rtl/cdb_arbiter_wb_fifo.sv
// Per-source result FIFO for the CDB writeback stage.
// Ports: push_i/data_i write, pop_i drops head_o, flush_i clears;
//   empty_o/full_o decoded from the registered count only.
//   A full FIFO refuses a push even when it pops that cycle;
//   flush wins over push and pop.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             empty_o,
  output logic             full_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Writeback stage: buffers arith/lsu/mul results per source and
// broadcasts one per cycle round-robin on a registered CDB.
// Ports: clk_i, reset_i (async, high), flush_i;
//   {alu,lsu,mul}_wb_{valid,tag,data}_i in, *_wb_ready_o out;
//   cdb_en_o/cdb_tag_o/cdb_data_o/cdb_src_o registered broadcast.
// Option: CDB_BYPASS_EN lets an empty source whose valid_i is high
//   compete directly and reach the CDB one cycle after the edge.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int TAG_W      = 5,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              alu_wb_valid_i,
  input  logic [TAG_W-1:0]  alu_wb_tag_i,
  input  logic [DATA_W-1:0] alu_wb_data_i,
  output logic              alu_wb_ready_o,
  input  logic              lsu_wb_valid_i,
  input  logic [TAG_W-1:0]  lsu_wb_tag_i,
  input  logic [DATA_W-1:0] lsu_wb_data_i,
  output logic              lsu_wb_ready_o,
  input  logic              mul_wb_valid_i,
  input  logic [TAG_W-1:0]  mul_wb_tag_i,
  input  logic [DATA_W-1:0] mul_wb_data_i,
  output logic              mul_wb_ready_o,
  output logic              cdb_en_o,
  output logic [TAG_W-1:0]  cdb_tag_o,
  output logic [DATA_W-1:0] cdb_data_o,
  output logic [1:0]        cdb_src_o
);

  localparam int EW = entry_w(TAG_W, DATA_W);

  logic [NUM_SRC-1:0] in_vld, empty, full;
  logic [NUM_SRC-1:0] push, pop, cand, use_in, byp;
  logic [EW-1:0]      in_ent [NUM_SRC];
  logic [EW-1:0]      head   [NUM_SRC];

  logic              gnt_vld;
  logic [1:0]        gnt_src;
  logic [EW-1:0]     gnt_ent;
  int                idx;

  logic [1:0]        rr_q, rr_d;
  logic              en_q, en_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        src_q, src_d;

  assign in_vld = {mul_wb_valid_i, lsu_wb_valid_i, alu_wb_valid_i};

  assign in_ent[SRC_ALU] = {alu_wb_tag_i, alu_wb_data_i};
  assign in_ent[SRC_LSU] = {lsu_wb_tag_i, lsu_wb_data_i};
  assign in_ent[SRC_MUL] = {mul_wb_tag_i, mul_wb_data_i};

  assign alu_wb_ready_o = ~full[SRC_ALU];
  assign lsu_wb_ready_o = ~full[SRC_LSU];
  assign mul_wb_ready_o = ~full[SRC_MUL];

`ifdef CDB_BYPASS_EN
  // An empty FIFO lets its live input compete for the grant.
  assign cand   = ~empty | in_vld;
  assign use_in = empty;
`else
  assign cand   = ~empty;
  assign use_in = '0;
`endif

  // Round-robin search starting at rr_q: ALU->LSU->MUL->ALU.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = SRC_ALU;
    gnt_ent = '0;
    idx     = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!gnt_vld && cand[i] && idx == i) begin
          gnt_vld = 1'b1;
          gnt_src = 2'(i);
          gnt_ent = use_in[i] ? in_ent[i] : head[i];
        end
      end
    end
  end

  genvar g;
  for (g = 0; g < NUM_SRC; g++) begin : g_src
    assign byp[g]  = gnt_vld && (gnt_src == 2'(g)) && use_in[g];
    assign pop[g]  = gnt_vld && (gnt_src == 2'(g)) && !empty[g];
    // A bypassed result goes straight to the CDB, never the FIFO.
    assign push[g] = in_vld[g] && !byp[g];

    wb_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .flush_i (flush_i),
      .push_i  (push[g]),
      .data_i  (in_ent[g]),
      .pop_i   (pop[g]),
      .empty_o (empty[g]),
      .full_o  (full[g]),
      .head_o  (head[g])
    );
  end

  always_comb begin
    rr_d   = rr_q;
    en_d   = 1'b0;
    tag_d  = tag_q;
    data_d = data_q;
    src_d  = src_q;
    if (flush_i) begin
      rr_d = SRC_ALU;
    end else if (gnt_vld) begin
      rr_d   = (gnt_src == SRC_MUL) ? SRC_ALU : gnt_src + 2'd1;
      en_d   = 1'b1;
      tag_d  = gnt_ent[EW-1:DATA_W];
      data_d = gnt_ent[DATA_W-1:0];
      src_d  = gnt_src;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_q   <= SRC_ALU;
      en_q   <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
      src_q  <= SRC_ALU;
    end else begin
      rr_q   <= rr_d;
      en_q   <= en_d;
      tag_q  <= tag_d;
      data_q <= data_d;
      src_q  <= src_d;
    end
  end

  assign cdb_en_o   = en_q;
  assign cdb_tag_o  = tag_q;
  assign cdb_data_o = data_q;
  assign cdb_src_o  = src_q;

endmodule
